fifo_to_packet: RTL and testbench
=================================

FIFO_TO_PACKET -- requirements
Module: fifo_to_packet

Interface
REQ-001 Parameter pPacketSize, default 64, packet length in bytes.
REQ-002 Parameter pFifoDataWidth, default 2, FIFO word width in bytes; pPacketSize SHALL be an integer multiple of it, otherwise elaboration SHALL fail.
REQ-003 Derived constants SHALL be: W = pFifoDataWidth*8 bits, P = pPacketSize*8 bits, N = pPacketSize/pFifoDataWidth words.
REQ-004 iClk  input  1  single clock, all logic on rising edge.
REQ-005 iRst  input  1  reset, asynchronous, active-high.
REQ-006 iPacketRd  input  1  one-cycle request to assemble one packet.
REQ-007 oPacketData  output  P  assembled packet; byte 0 in bits [7:0].
REQ-008 oPacketDone  output  1  one-cycle pulse, packet complete.
REQ-009 oBusy  output  1  high while a packet is being assembled.
REQ-010 oErr  output  1  one-cycle pulse, request rejected.
REQ-011 oRdEn  output  1  FIFO read strobe, one word per high cycle.
REQ-012 iRdEmpty  input  1  FIFO empty flag.
REQ-013 iRdData  input  W  FIFO read data, valid the cycle after oRdEn is sampled high.

Function
REQ-014 States SHALL be IDLE, READ, DRAIN, DONE.
REQ-015 IDLE: iPacketRd high -> READ, clear issue counter and capture counter.
REQ-016 READ: oRdEn SHALL be combinationally (state==READ && !iRdEmpty && issued<N).
REQ-017 Each cycle oRdEn is high, the issue counter SHALL increment; at issued==N the state SHALL go to DRAIN.
REQ-018 A registered valid flag (oRdEn delayed one cycle) SHALL capture iRdData into oPacketData[c*W +: W], c = capture counter, then increment c.
REQ-019 Word order SHALL match the upstream writer: first FIFO word -> lowest W bits.
REQ-020 DRAIN: when c reaches N -> DONE.
REQ-021 DONE: oPacketDone high for exactly one cycle, then IDLE.
REQ-022 oBusy SHALL be high in READ, DRAIN, DONE.
REQ-023 Latency with FIFO never empty: iPacketRd sampled at edge k -> oRdEn high for edges k+1..k+N -> last capture at k+N+1 -> oPacketDone high between edges k+N+2 and k+N+3.
REQ-024 iRdEmpty high SHALL stall oRdEn with no words lost or duplicated; no timeout.
REQ-025 oRdEn SHALL never assert while iRdEmpty is high, outside READ, or after N issues.
REQ-026 iPacketRd while oBusy SHALL pulse oErr for one cycle and be ignored; assembly continues undisturbed.
REQ-027 iPacketRd in the same cycle as oPacketDone SHALL be rejected (oErr); first accepted request is the cycle after.
REQ-028 oPacketData SHALL hold its value from oPacketDone until the next accepted request; contents mid-assembly are undefined to consumers.
REQ-029 Counters SHALL be sized to hold N without wrap.

Reset
REQ-030 iRst high SHALL immediately force state IDLE, counters 0, valid flag 0, oPacketData 0, oRdEn/oPacketDone/oBusy/oErr 0.
REQ-031 Reset mid-packet SHALL abandon the packet; no oPacketDone; next request after release starts a fresh packet at word 0.

Verification
REQ-032 Reset: assert iRst 40 ps asynchronously -> all outputs 0 before next clock edge.
REQ-033 Counter packet: FIFO model preloaded with bytes 0..63, never empty, pulse iPacketRd -> exactly 32 oRdEn cycles, oPacketDone at k+34, oPacketData byte i == i for all i.
REQ-034 Empty stalls: iRdEmpty high for 5 cycles after word 10 -> oRdEn low during stall, final packet still bytes 0..63, oPacketDone delayed by 5 cycles.
REQ-035 Busy request: second iPacketRd at word 5 -> oErr one-cycle pulse, exactly 32 words read, one oPacketDone.
REQ-036 Reset mid-packet at word 16 -> no oPacketDone; new request reads 32 fresh words (bytes 0x40..0x7F) into correct positions.
REQ-037 Back-to-back: request the cycle after oPacketDone -> accepted, second packet correct, no oErr.

Source files
------------

// File: rtl/fifo_to_packet.sv
// Purpose : pulls N words from a show-ahead-less FIFO and assembles them into one P-bit packet.
// Latency : request sampled at edge k -> words read on edges k+1..k+N -> oPacketDone between k+N+2 and k+N+3.
// Backpr. : iRdEmpty stalls the read strobe indefinitely; requests while busy are rejected with oErr.
//
// Ports:
//   iClk, iRst          clock, asynchronous active-high reset
//   iPacketRd           one-cycle request to assemble a packet
//   oPacketData         assembled packet, first FIFO word in the lowest W bits
//   oPacketDone         one-cycle pulse when the packet is complete
//   oBusy               high from an accepted request until the done cycle ends
//   oErr                one-cycle pulse when a request is rejected
//   oRdEn/iRdEmpty      FIFO read strobe and empty flag
//   iRdData             FIFO read data, valid the cycle after oRdEn
`timescale 1ns/1ps

module fifo_to_packet #(
  parameter int pPacketSize    = 64,
  parameter int pFifoDataWidth = 2
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iPacketRd,
  output logic [pPacketSize*8-1:0] oPacketData,
  output logic                     oPacketDone,
  output logic                     oBusy,
  output logic                     oErr,
  output logic                     oRdEn,
  input  logic                     iRdEmpty,
  input  logic [pFifoDataWidth*8-1:0] iRdData
);

  localparam int W     = pFifoDataWidth * 8;
  localparam int P     = pPacketSize * 8;
  localparam int N     = pPacketSize / pFifoDataWidth;
  localparam int CNT_W = $clog2(N + 1);

  generate
    if ((pPacketSize % pFifoDataWidth) != 0) begin : g_bad_size
      $error("fifo_to_packet: pPacketSize must be a multiple of pFifoDataWidth");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] issued;   // words requested from the FIFO
  logic [CNT_W-1:0] cap;      // words written into the packet
  logic             rd_vld;   // iRdData holds a word this cycle
  logic [P-1:0]     data;
  logic             err;

  // The strobe is combinational so the FIFO sees it in the same cycle the
  // empty flag drops; it can never fire outside READ or past N issues.
  assign oRdEn       = (state == READ) && !iRdEmpty && (issued < CNT_W'(N));
  assign oBusy       = (state != IDLE);
  assign oPacketDone = (state == DONE);
  assign oPacketData = data;
  assign oErr        = err;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state  <= IDLE;
      issued <= '0;
      cap    <= '0;
      rd_vld <= 1'b0;
      data   <= '0;
      err    <= 1'b0;
    end else begin
      rd_vld <= oRdEn;
      // DONE counts as busy, so a request coinciding with oPacketDone is rejected.
      err    <= iPacketRd && (state != IDLE);

      if (rd_vld) begin
        data[cap*W +: W] <= iRdData;
        cap              <= cap + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (iPacketRd) begin
            state  <= READ;
            issued <= '0;
            cap    <= '0;
          end
        end
        READ: begin
          if (oRdEn) begin
            issued <= issued + CNT_W'(1);
            // Leave READ on the edge that issues the last word.
            if (issued == CNT_W'(N - 1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The final word lands one edge after its strobe; wait for it.
          if (cap == CNT_W'(N)) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_to_packet.sv
`timescale 1ns/1ps

module tb_fifo_to_packet;

  localparam int PKT = 64;
  localparam int FW  = 2;
  localparam int W   = FW * 8;
  localparam int P   = PKT * 8;
  localparam int N   = PKT / FW;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iPacketRd;
  logic [P-1:0]  oPacketData;
  logic          oPacketDone;
  logic          oBusy;
  logic          oErr;
  logic          oRdEn;
  logic          iRdEmpty;
  logic [W-1:0]  iRdData;

  fifo_to_packet #(
    .pPacketSize    (PKT),
    .pFifoDataWidth (FW)
  ) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iPacketRd   (iPacketRd),
    .oPacketData (oPacketData),
    .oPacketDone (oPacketDone),
    .oBusy       (oBusy),
    .oErr        (oErr),
    .oRdEn       (oRdEn),
    .iRdEmpty    (iRdEmpty),
    .iRdData     (iRdData)
  );

  always #5 iClk = ~iClk;

  // FIFO model: a byte stream starting at fifo_base, two bytes per word,
  // lower-addressed byte in the low half; data appears the edge after the strobe.
  logic [7:0] fifo_ptr;
  logic [7:0] fifo_base;
  logic       fifo_load;

  always @(posedge iClk) begin
    if (fifo_load) begin
      fifo_ptr <= fifo_base;
    end else if (oRdEn) begin
      iRdData  <= {fifo_ptr + 8'd1, fifo_ptr};
      fifo_ptr <= fifo_ptr + 8'd2;
    end
  end

  // Event counters, only ever written here.
  int edge_cnt = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int viol_cnt = 0;

  always @(posedge iClk) begin
    edge_cnt <= edge_cnt + 1;
    if (oRdEn)             rd_cnt   <= rd_cnt + 1;
    if (oPacketDone)       done_cnt <= done_cnt + 1;
    if (oErr)              err_cnt  <= err_cnt + 1;
    if (oRdEn && iRdEmpty) viol_cnt <= viol_cnt + 1;
  end

  int n_checks = 0;
  int n_err    = 0;
  logic [P-1:0] exp_q[$];

  task automatic check(input string tag, input logic [P-1:0] got, input logic [P-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [P-1:0] make_pkt(input logic [7:0] base);
    logic [P-1:0] p;
    p = '0;
    for (int i = 0; i < PKT; i++) begin
      p[i*8 +: 8] = base + 8'(i);
    end
    return p;
  endfunction

  task automatic load_fifo(input logic [7:0] base);
    @(negedge iClk);
    fifo_base = base;
    fifo_load = 1'b1;
    @(negedge iClk);
    fifo_load = 1'b0;
  endtask

  // Request is sampled on the edge between the two negedges (edge k).
  task automatic pulse_req();
    @(negedge iClk);
    iPacketRd = 1'b1;
    @(negedge iClk);
    iPacketRd = 1'b0;
  endtask

  // Issues one request and follows it to oPacketDone, optionally stalling
  // the FIFO for 5 cycles or firing a second request once stall_at/busy_at
  // words have been read. Returns at the negedge where oPacketDone is high.
  task automatic run_packet(input string tag, input logic [7:0] base,
                            input int stall_at, input int busy_at, input int exp_lat);
    int rd0, err0, k, stall_left, busy_ph;
    bit stalled;
    logic [P-1:0] exp;
    rd0  = rd_cnt;
    err0 = err_cnt;
    exp_q.push_back(make_pkt(base));
    pulse_req();
    k = edge_cnt;
    check({tag, "_busy"}, P'(oBusy), P'(1));
    stall_left = 0;
    stalled    = 1'b0;
    busy_ph    = 0;
    while (!oPacketDone && (edge_cnt - k) < 200) begin
      if (stall_left > 0) begin
        check({tag, "_stall_rden"}, P'(oRdEn), P'(0));
        stall_left--;
        if (stall_left == 0) iRdEmpty = 1'b0;
      end else if (stall_at >= 0 && !stalled && (rd_cnt - rd0) == stall_at) begin
        iRdEmpty   = 1'b1;
        stall_left = 5;
        stalled    = 1'b1;
      end
      if (busy_ph == 1) begin
        iPacketRd = 1'b0;
        check({tag, "_err_hi"}, P'(oErr), P'(1));
        busy_ph = 2;
      end else if (busy_ph == 2) begin
        check({tag, "_err_lo"}, P'(oErr), P'(0));
        busy_ph = 3;
      end else if (busy_at >= 0 && busy_ph == 0 && (rd_cnt - rd0) == busy_at) begin
        iPacketRd = 1'b1;
        busy_ph   = 1;
      end
      @(negedge iClk);
    end
    iRdEmpty  = 1'b0;
    iPacketRd = 1'b0;
    check({tag, "_done_seen"}, P'(oPacketDone), P'(1));
    check({tag, "_latency"}, P'(edge_cnt - k), P'(exp_lat));
    check({tag, "_rd_words"}, P'(rd_cnt - rd0), P'(N));
    check({tag, "_err_cnt"}, P'(err_cnt - err0), P'((busy_at >= 0) ? 1 : 0));
    check({tag, "_sb_pending"}, P'(exp_q.size()), P'(1));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_data"}, oPacketData, exp);
  endtask

  // One cycle after done: pulse over, block idle, packet still held.
  task automatic after_done(input string tag, input logic [7:0] base);
    @(negedge iClk);
    check({tag, "_done_pulse"}, P'({oPacketDone, oBusy}), P'(0));
    check({tag, "_hold"}, oPacketData, make_pkt(base));
  endtask

  initial begin
    int d0, e0, r0, t0;
    iRst      = 1'b1;
    iPacketRd = 1'b0;
    iRdEmpty  = 1'b0;
    fifo_base = 8'h00;
    fifo_load = 1'b0;
    repeat (3) @(negedge iClk);
    check("reset_ctrl", P'({oRdEn, oPacketDone, oBusy, oErr}), P'(0));
    check("reset_data", oPacketData, '0);
    iRst = 1'b0;

    // Counter packet, FIFO never empty.
    load_fifo(8'h00);
    run_packet("cnt", 8'h00, -1, -1, N + 2);
    after_done("cnt", 8'h00);

    // Five-cycle empty stall after word 10, then a request in the done cycle.
    load_fifo(8'h00);
    run_packet("stall", 8'h00, 10, -1, N + 2 + 5);
    e0 = err_cnt;
    r0 = rd_cnt;
    iPacketRd = 1'b1;
    @(negedge iClk);
    iPacketRd = 1'b0;
    check("same_cycle_err", P'({oErr, oBusy}), P'(2'b10));
    @(negedge iClk);
    check("same_cycle_idle", P'({oErr, oBusy}), P'(0));
    check("same_cycle_errcnt", P'(err_cnt - e0), P'(1));
    check("same_cycle_noread", P'(rd_cnt - r0), P'(0));

    // Second request while busy at word 5.
    load_fifo(8'h00);
    d0 = done_cnt;
    run_packet("busyreq", 8'h00, -1, 5, N + 2);
    after_done("busyreq", 8'h00);
    check("busyreq_done_cnt", P'(done_cnt - d0), P'(1));

    // Reset mid-packet at word 16, then a fresh packet from bytes 0x40.
    load_fifo(8'h00);
    d0 = done_cnt;
    r0 = rd_cnt;
    pulse_req();
    t0 = edge_cnt;
    while ((rd_cnt - r0) < 16 && (edge_cnt - t0) < 200) @(negedge iClk);
    check("abort_reached", P'(rd_cnt - r0), P'(16));
    iRst = 1'b1;
    #0.04;
    check("async_rst_ctrl", P'({oRdEn, oPacketDone, oBusy, oErr}), P'(0));
    check("async_rst_data", oPacketData, '0);
    @(negedge iClk);
    iRst = 1'b0;
    repeat (40) @(negedge iClk);
    check("abort_no_done", P'(done_cnt - d0), P'(0));
    check("abort_idle", P'(oBusy), P'(0));
    load_fifo(8'h40);
    run_packet("fresh", 8'h40, -1, -1, N + 2);
    after_done("fresh", 8'h40);

    // Back-to-back: second request the cycle after oPacketDone.
    load_fifo(8'h00);
    e0 = err_cnt;
    run_packet("b2b_a", 8'h00, -1, -1, N + 2);
    run_packet("b2b_b", 8'h40, -1, -1, N + 2);
    after_done("b2b_b", 8'h40);
    check("b2b_no_err", P'(err_cnt - e0), P'(0));

    check("rden_while_empty", P'(viol_cnt), P'(0));
    check("sb_drained", P'(exp_q.size()), P'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
